// File: rtl/pc_fetch.sv
// Instruction-fetch front end: PC owner, imem req/ack master, fetch FIFO.
// Optional FETCH_ALIGN_CHK_EN adds if_exc_adel for misaligned redirects.
module pc_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
`ifdef FETCH_ALIGN_CHK_EN
    ,
    output logic        if_exc_adel
`endif
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam logic [AW:0] CNT_DEPTH = BUF_DEPTH[AW:0];

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } state_t;

    state_t state;
    state_t state_nx;

    logic [31:0] next_pc;
    logic [31:0] redir_pc;
    logic        halted;
    logic        halted_nx;
    logic        misalign;

    logic [31:0] pc_mem   [BUF_DEPTH];
    logic [31:0] inst_mem [BUF_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nx;
    logic [AW:0]   count_after;

    logic        push;
    logic        pop;
    logic        go_fetch;
    logic        wr_en;
    logic [AW-1:0] wr_idx;
    logic [31:0] wr_pc;
    logic [31:0] wr_inst;

`ifdef FETCH_ALIGN_CHK_EN
    logic exc_mem [BUF_DEPTH];
    assign misalign = flush && (redirect_pc[1:0] != 2'b00);
`else
    logic unused_bits;
    assign unused_bits = ^redirect_pc[1:0];
    assign misalign = 1'b0;
`endif

    assign redir_pc = {redirect_pc[31:2], 2'b00};

    assign imem_req  = (state == REQ);
    assign imem_addr = next_pc;

    assign if_valid = (count != '0);
    assign if_pc    = if_valid ? pc_mem[rd_ptr] : 32'h0;
    assign if_inst  = if_valid ? inst_mem[rd_ptr] : 32'h0;
`ifdef FETCH_ALIGN_CHK_EN
    assign if_exc_adel = if_valid && exc_mem[rd_ptr];
`endif

    // Flush outranks both sides of the FIFO; an ack during flush is dropped.
    assign push = imem_req && imem_ack && !flush;
    assign pop  = if_valid && !stall && !flush;

    // Occupancy after this cycle's push/pop, then after a possible flush.
    always_comb begin
        count_nx = count;
        if (push && !pop) begin
            count_nx = count + 1'b1;
        end else if (pop && !push) begin
            count_nx = count - 1'b1;
        end
        count_after = count_nx;
        if (flush) begin
            count_after = misalign ? {{AW{1'b0}}, 1'b1} : '0;
        end
    end

    assign halted_nx = flush ? misalign : halted;
    assign go_fetch  = !halted_nx && (count_after < CNT_DEPTH);

    // Next-state: one outstanding request, DROP swallows a stale ack.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                state_nx = go_fetch ? REQ : IDLE;
            end
            REQ: begin
                if (flush && !imem_ack) begin
                    state_nx = DROP;
                end else if (flush || imem_ack) begin
                    state_nx = go_fetch ? REQ : IDLE;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_nx = go_fetch ? REQ : IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // FSM state, fetch PC and halt flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            next_pc <= RESET_PC;
            halted  <= 1'b0;
        end else begin
            state  <= state_nx;
            halted <= halted_nx;
            if (flush) begin
                next_pc <= redir_pc;
            end else if (push) begin
                next_pc <= next_pc + 32'd4;
            end
        end
    end

    // A misaligned redirect plants one exception entry at slot 0.
    always_comb begin
        wr_en   = !rst && (push || misalign);
        wr_idx  = misalign ? '0 : wr_ptr;
        wr_pc   = misalign ? redirect_pc : next_pc;
        wr_inst = misalign ? 32'h0 : imem_rdata;
    end

    // FIFO storage; contents are masked by if_valid so no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wr_idx]   <= wr_pc;
            inst_mem[wr_idx] <= wr_inst;
`ifdef FETCH_ALIGN_CHK_EN
            exc_mem[wr_idx]  <= misalign;
`endif
        end
    end

    // FIFO pointers and occupancy; pointers wrap modulo BUF_DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= misalign ? AW'(1) : '0;
            count  <= count_after;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nx;
        end
    end

endmodule
